// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared mode encodings for the LED sequencer
package led_seq_pkg;

  localparam logic [1:0] MODE_BIN     = 2'd0;
  localparam logic [1:0] MODE_SCAN    = 2'd1;
  localparam logic [1:0] MODE_GRAY    = 2'd2;
  localparam logic [1:0] MODE_BREATHE = 2'd3;

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler producing one step strobe every 2^LOG2DELAY enabled clocks
module tick_gen #(
  parameter int LOG2DELAY = 21
) (
  input  logic clk,
  input  logic resetn,
  input  logic en,
  input  logic clr,
  output logic step
);

  logic [LOG2DELAY-1:0] presc_q;
  logic [LOG2DELAY-1:0] presc_d;

  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = presc_q + LOG2DELAY'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // A clear landing on the terminal count swallows that step.
  assign step = en && !clr && (presc_q == '1);

endmodule

// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - LED pattern sequencer: binary, scan, gray and breathe modes
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int N_LEDS    = 5,
  parameter int LOG2DELAY = 21,
  parameter int PWM_BITS  = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              dir,
  output logic [N_LEDS-1:0] led,
  output logic              tick
);

  localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;

  logic [1:0]          mode_q;
  logic [N_LEDS-1:0]   count_q, count_d;
  logic [N_LEDS-1:0]   pos_q, pos_d;
  logic                up_q, up_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                duty_up_q, duty_up_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [N_LEDS-1:0]   led_q, led_d;
  logic                tick_q, tick_d;
  logic                mode_chg;
  logic                step;

  assign mode_chg = (mode != mode_q);

  tick_gen #(
    .LOG2DELAY(LOG2DELAY)
  ) u_tick_gen (
    .clk   (clk),
    .resetn(resetn),
    .en    (en),
    .clr   (mode_chg),
    .step  (step)
  );

  always_comb begin
    count_d   = count_q;
    pos_d     = pos_q;
    up_d      = up_q;
    duty_d    = duty_q;
    duty_up_d = duty_up_q;
    pwm_d     = pwm_q;
    tick_d    = step;

    if (en) begin
      pwm_d = pwm_q + PWM_BITS'(1);
    end

    if (step) begin
      case (mode_q)
        MODE_BIN, MODE_GRAY: begin
          count_d = dir ? (count_q - N_LEDS'(1)) : (count_q + N_LEDS'(1));
        end
        MODE_SCAN: begin
          // Bounce between the end bits; a single LED simply stays lit.
          if (N_LEDS > 1) begin
            if (up_q) begin
              if (pos_q[N_LEDS-1]) begin
                pos_d = pos_q >> 1;
                up_d  = 1'b0;
              end else begin
                pos_d = pos_q << 1;
              end
            end else begin
              if (pos_q[0]) begin
                pos_d = pos_q << 1;
                up_d  = 1'b1;
              end else begin
                pos_d = pos_q >> 1;
              end
            end
          end
        end
        MODE_BREATHE: begin
          if (duty_up_q) begin
            if (duty_q == DUTY_MAX) begin
              duty_d    = duty_q - PWM_BITS'(1);
              duty_up_d = 1'b0;
            end else begin
              duty_d = duty_q + PWM_BITS'(1);
            end
          end else begin
            if (duty_q == '0) begin
              duty_d    = duty_q + PWM_BITS'(1);
              duty_up_d = 1'b1;
            end else begin
              duty_d = duty_q - PWM_BITS'(1);
            end
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end

    if (mode_chg) begin
      count_d   = '0;
      pos_d     = N_LEDS'(1);
      up_d      = 1'b1;
      duty_d    = '0;
      duty_up_d = 1'b1;
      pwm_d     = '0;
    end

    case (mode_q)
      MODE_BIN:     led_d = count_q;
      MODE_GRAY:    led_d = count_q ^ (count_q >> 1);
      MODE_SCAN:    led_d = pos_q;
      MODE_BREATHE: led_d = {N_LEDS{pwm_q < duty_q}};
      default:      led_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_q    <= mode;
      count_q   <= '0;
      pos_q     <= N_LEDS'(1);
      up_q      <= 1'b1;
      duty_q    <= '0;
      duty_up_q <= 1'b1;
      pwm_q     <= '0;
      led_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      mode_q    <= mode;
      count_q   <= count_d;
      pos_q     <= pos_d;
      up_q      <= up_d;
      duty_q    <= duty_d;
      duty_up_q <= duty_up_d;
      pwm_q     <= pwm_d;
      led_q     <= led_d;
      tick_q    <= tick_d;
    end
  end

  assign led  = led_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - scoreboard bench for led_sequencer
module tb_led_sequencer;

  localparam int NL = 5;
  localparam int LD = 2;
  localparam int PB = 3;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          en = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          dir = 1'b0;
  logic [NL-1:0] led;
  logic          tick;

  int vectors = 0;
  int errors  = 0;

  logic [NL-1:0] exp_q[$];
  bit            mon_en = 1'b0;
  logic          tick_d = 1'b0;

  always #5 clk = ~clk;

  led_sequencer #(
    .N_LEDS   (NL),
    .LOG2DELAY(LD),
    .PWM_BITS (PB)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .en    (en),
    .mode  (mode),
    .dir   (dir),
    .led   (led),
    .tick  (tick)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The LED value for a step is visible the clock after its tick.
  always @(negedge clk) begin
    if (!mon_en) begin
      tick_d = 1'b0;
    end else begin
      if (tick_d) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_step", 32'd0, 32'd1);
        end else begin
          check("sb_led", led, exp_q.pop_front());
        end
      end
      tick_d = tick;
    end
  end

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [1:0] m, input logic d);
    mon_en = 1'b0;
    resetn = 1'b0;
    en     = 1'b1;
    mode   = m;
    dir    = d;
    exp_q.delete();
    adv();
    adv();
    resetn = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic finish_sb(input string name);
    adv();
    check(name, exp_q.size(), 32'd0);
  endtask

  logic [NL-1:0] scan_tab[9] = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
                                 5'b00100, 5'b00010, 5'b00001, 5'b00010};
  logic [NL-1:0] gray_tab[4] = '{5'b00001, 5'b00011, 5'b00010, 5'b00110};

  initial begin
    logic [NL-1:0] v;
    int            pwm_m, duty_m, presc_m;
    bit            dup;
    logic [NL-1:0] exp_led;
    logic          exp_tick;

    en   = 1'b1;
    adv();
    check("rst_led", led, 32'd0);
    check("rst_tick", tick, 32'd0);

    // Binary up: latency then a full 32-step wrap
    start(2'd0, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      v = i[NL-1:0];
      exp_q.push_back(v);
    end
    for (int i = 1; i <= 3; i++) begin
      adv();
      check("bin_no_tick_early", tick, 32'd0);
    end
    adv();
    check("bin_tick_e4", tick, 32'd1);
    check("bin_led_before", led, 32'd0);
    adv();
    check("bin_tick_one_cycle", tick, 32'd0);
    check("bin_led_first", led, 32'd1);
    repeat (125) adv();
    check("bin_wrap", led, 32'd0);
    finish_sb("bin_up_drained");

    // en low mid-count holds everything
    start(2'd0, 1'b0);
    exp_q.push_back(5'd1);
    exp_q.push_back(5'd2);
    repeat (6) adv();
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      adv();
      check("hold_led", led, 32'd1);
      check("hold_tick", tick, 32'd0);
    end
    en = 1'b1;
    adv();
    check("hold_presc_no_tick", tick, 32'd0);
    adv();
    check("hold_presc_tick", tick, 32'd1);
    adv();
    check("hold_led_after", led, 32'd2);
    finish_sb("hold_drained");

    // Binary down
    start(2'd0, 1'b1);
    exp_q.push_back(5'b11111);
    exp_q.push_back(5'b11110);
    repeat (10) adv();
    finish_sb("bin_down_drained");

    // Gray
    start(2'd2, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(gray_tab[i]);
    repeat (18) adv();
    finish_sb("gray_drained");

    // Scan bounce, then a reset pulse on a strobe cycle
    start(2'd1, 1'b0);
    for (int i = 0; i < 9; i++) exp_q.push_back(scan_tab[i]);
    adv();
    check("scan_init", led, 32'd1);
    repeat (38) adv();
    check("scan_drained", exp_q.size(), 32'd0);
    mon_en = 1'b0;
    resetn = 1'b0;
    adv();
    check("scan_rst_led", led, 32'd0);
    check("scan_rst_tick", tick, 32'd0);
    resetn = 1'b1;
    adv();
    check("scan_rel_led", led, 32'd1);
    check("scan_rel_tick1", tick, 32'd0);
    adv();
    check("scan_rel_tick2", tick, 32'd0);
    adv();
    check("scan_rel_tick3", tick, 32'd0);
    adv();
    check("scan_rel_tick4", tick, 32'd1);

    // Mode change 0 -> 1 mid-count
    start(2'd0, 1'b0);
    exp_q.push_back(5'd1);
    exp_q.push_back(5'b00010);
    repeat (6) adv();
    mode = 2'd1;
    adv();
    adv();
    check("mchg_led_pos0", led, 32'd1);
    check("mchg_tick8", tick, 32'd0);
    adv();
    check("mchg_tick9", tick, 32'd0);
    adv();
    check("mchg_tick10", tick, 32'd0);
    adv();
    check("mchg_tick11", tick, 32'd1);
    check("mchg_led_at_step", led, 32'd1);
    adv();
    check("mchg_led_moved", led, 32'b00010);
    finish_sb("mchg_drained");

    // Breathe: per-cycle reference of the triangle duty and free PWM
    start(2'd3, 1'b0);
    mon_en  = 1'b0;
    pwm_m   = 0;
    duty_m  = 0;
    presc_m = 0;
    dup     = 1'b1;
    for (int c = 0; c < 40; c++) begin
      exp_led  = (pwm_m < duty_m) ? 5'b11111 : 5'b00000;
      exp_tick = (presc_m == 3);
      if (presc_m == 3) begin
        if (dup) begin
          if (duty_m == 7) begin duty_m = 6; dup = 1'b0; end
          else duty_m = duty_m + 1;
        end else begin
          if (duty_m == 0) begin duty_m = 1; dup = 1'b1; end
          else duty_m = duty_m - 1;
        end
      end
      pwm_m   = (pwm_m + 1) % 8;
      presc_m = (presc_m + 1) % 4;
      adv();
      check("breathe_led", led, exp_led);
      check("breathe_tick", tick, exp_tick);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
